// File: rtl/forwarding_hazard_unit_if.sv
// Signal bundle between the pipeline control logic and the forwarding/hazard unit.
// master: the pipeline side (drives stage addresses and flags, consumes controls).
// slave:  the forwarding/hazard unit.
interface forwarding_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    // ID-stage sources
    logic [ADDR_W-1:0] rs_addr_fd;
    logic [ADDR_W-1:0] rt_addr_fd;
    logic              uses_rs_fd;
    logic              uses_rt_fd;
    // DX-stage producer
    logic [ADDR_W-1:0] write_reg_addr_dx;
    logic              write_reg_dx;
    logic              mem_read_dx;
    // XM-stage producer
    logic [ADDR_W-1:0] write_reg_addr_xm;
    logic              write_reg_xm;
    logic              mem_read_xm;
    logic              mem_ready;
    // Control outputs
    logic              stall_fd;
    logic              bubble_dx;
    logic              freeze;
    logic [1:0]        alu_a_mux_sel;
    logic [1:0]        alu_b_mux_sel;
    logic              timeout_err;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output rs_addr_fd, rt_addr_fd, uses_rs_fd, uses_rt_fd,
        output write_reg_addr_dx, write_reg_dx, mem_read_dx,
        output write_reg_addr_xm, write_reg_xm, mem_read_xm, mem_ready,
        input  stall_fd, bubble_dx, freeze, alu_a_mux_sel, alu_b_mux_sel,
        input  timeout_err, stall_cycles
    );

    modport slave (
        input  rs_addr_fd, rt_addr_fd, uses_rs_fd, uses_rt_fd,
        input  write_reg_addr_dx, write_reg_dx, mem_read_dx,
        input  write_reg_addr_xm, write_reg_xm, mem_read_xm, mem_ready,
        output stall_fd, bubble_dx, freeze, alu_a_mux_sel, alu_b_mux_sel,
        output timeout_err, stall_cycles
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and hazard control for the 5-stage pipeline.
// ALU bypass selects are computed in ID and registered so they are valid while the
// instruction sits in DX. Load-use hazards produce a one-cycle stall plus bubble;
// a load waiting in XM for mem_ready freezes the whole pipeline, bounded by MAX_WAIT.
module forwarding_hazard_unit #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input logic                    clk,
    input logic                    rst,
    forwarding_hazard_unit_if.slave hz
);
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MAX_WAIT - 1);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_XM = 2'b10;
    localparam logic [1:0] SEL_MW = 2'b01;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_set;
    logic              last;
    logic              freeze_raw;
    logic              hazard_raw;
    logic              dx_valid, xm_valid;
    logic [1:0]        sel_a_q, sel_b_q;
    logic [1:0]        sel_a_nxt, sel_b_nxt;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    function automatic logic valid_prod(input logic we, input logic [ADDR_W-1:0] addr);
        return we && ((ZERO_REG == 0) || (addr != '0));
    endfunction

    // Younger (DX) producer takes priority over the older (XM) one.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [ADDR_W-1:0] src,
                                           input logic dxv, input logic [ADDR_W-1:0] dxa,
                                           input logic xmv, input logic [ADDR_W-1:0] xma);
        if (!used)                  return SEL_RF;
        else if (dxv && src == dxa) return SEL_XM;
        else if (xmv && src == xma) return SEL_MW;
        else                        return SEL_RF;
    endfunction

    // Producer validity, memory-wait freeze and load-use detection
    always_comb begin
        dx_valid   = valid_prod(hz.write_reg_dx, hz.write_reg_addr_dx);
        xm_valid   = valid_prod(hz.write_reg_xm, hz.write_reg_addr_xm);
        last       = (state == ST_MEM_WAIT) && (wait_cnt == LAST_CNT);
        freeze_raw = hz.mem_read_xm & ~hz.mem_ready & ~last;
        hazard_raw = ~freeze_raw & hz.mem_read_dx & dx_valid &
                     ((hz.uses_rs_fd && hz.rs_addr_fd == hz.write_reg_addr_dx) ||
                      (hz.uses_rt_fd && hz.rt_addr_fd == hz.write_reg_addr_dx));
        sel_a_nxt  = fwd_sel(hz.uses_rs_fd, hz.rs_addr_fd, dx_valid, hz.write_reg_addr_dx,
                             xm_valid, hz.write_reg_addr_xm);
        sel_b_nxt  = fwd_sel(hz.uses_rt_fd, hz.rt_addr_fd, dx_valid, hz.write_reg_addr_dx,
                             xm_valid, hz.write_reg_addr_xm);
    end

    // Memory-wait FSM next state; a ready on the last wait cycle beats the timeout
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        case (state)
            ST_RUN: begin
                if (freeze_raw) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            ST_MEM_WAIT: begin
                wait_cnt_nxt = wait_cnt + 1'b1;
                if (hz.mem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (last) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                    timeout_set  = 1'b1;
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Bypass select registers: held during freeze, cleared by a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else if (freeze_raw) begin
            sel_a_q <= sel_a_q;
            sel_b_q <= sel_b_q;
        end else if (hazard_raw) begin
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            sel_a_q <= sel_a_nxt;
            sel_b_q <= sel_b_nxt;
        end
    end

    // Sticky timeout flag and saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (timeout_set)
                err_q <= 1'b1;
            if ((freeze_raw | hazard_raw) && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Combinational controls are masked by reset so they drop immediately
    always_comb begin
        hz.freeze        = freeze_raw & ~rst;
        hz.stall_fd      = hazard_raw & ~rst;
        hz.bubble_dx     = hazard_raw & ~rst;
        hz.alu_a_mux_sel = sel_a_q;
        hz.alu_b_mux_sel = sel_b_q;
        hz.timeout_err   = err_q;
        hz.stall_cycles  = cnt_q;
    end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_forwarding_hazard_unit;
    localparam int AW   = 5;
    localparam int CW   = 16;
    localparam int MW   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // behavioural model state
    int   pend;          // consecutive cycles the current XM load has been frozen
    int   m_a, m_b;      // expected registered selects
    int   m_err;
    int   m_cnt;
    int   e_frz, e_haz;  // expectations for the cycle being evaluated

    forwarding_hazard_unit_if #(.ADDR_W(AW), .CNT_W(CW)) hz ();

    forwarding_hazard_unit #(.ADDR_W(AW), .ZERO_REG(1), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int valid(input int we, input int a);
        return (we != 0 && a != 0) ? 1 : 0;
    endfunction

    function automatic int fwd(input int used, input int src);
        if (used == 0) return 0;
        if (valid(hz.write_reg_dx, hz.write_reg_addr_dx) != 0 && src == int'(hz.write_reg_addr_dx)) return 2;
        if (valid(hz.write_reg_xm, hz.write_reg_addr_xm) != 0 && src == int'(hz.write_reg_addr_xm)) return 1;
        return 0;
    endfunction

    task automatic set_in(input int rs, input int rt, input int urs, input int urt,
                          input int dxa, input int wdx, input int mdx,
                          input int xma, input int wxm, input int mxm, input int rdy);
        hz.rs_addr_fd        = AW'(rs);
        hz.rt_addr_fd        = AW'(rt);
        hz.uses_rs_fd        = urs[0];
        hz.uses_rt_fd        = urt[0];
        hz.write_reg_addr_dx = AW'(dxa);
        hz.write_reg_dx      = wdx[0];
        hz.mem_read_dx       = mdx[0];
        hz.write_reg_addr_xm = AW'(xma);
        hz.write_reg_xm      = wxm[0];
        hz.mem_read_xm       = mxm[0];
        hz.mem_ready         = rdy[0];
    endtask

    // Evaluate at the falling edge: derive expectations and compare every output.
    task automatic eval_cycle();
        int hit;
        @(negedge clk);
        e_frz = (hz.mem_read_xm && !hz.mem_ready && pend < MW) ? 1 : 0;
        hit = ((hz.uses_rs_fd && hz.rs_addr_fd == hz.write_reg_addr_dx) ||
               (hz.uses_rt_fd && hz.rt_addr_fd == hz.write_reg_addr_dx)) ? 1 : 0;
        e_haz = (e_frz == 0 && hz.mem_read_dx && hit != 0 &&
                 valid(hz.write_reg_dx, hz.write_reg_addr_dx) != 0) ? 1 : 0;
        chk("freeze", hz.freeze, e_frz);
        chk("stall_fd", hz.stall_fd, e_haz);
        chk("bubble_dx", hz.bubble_dx, e_haz);
        chk("alu_a_mux_sel", hz.alu_a_mux_sel, m_a);
        chk("alu_b_mux_sel", hz.alu_b_mux_sel, m_b);
        chk("timeout_err", hz.timeout_err, m_err);
        chk("stall_cycles", hz.stall_cycles, m_cnt);
    endtask

    // Apply the clock edge to the model, then move to just after the DUT edge.
    task automatic adv();
        if ((e_frz | e_haz) != 0 && m_cnt < MAXC) m_cnt++;
        if (e_frz == 0) begin
            if (e_haz != 0) begin
                m_a = 0;
                m_b = 0;
            end else begin
                m_a = fwd(hz.uses_rs_fd, hz.rs_addr_fd);
                m_b = fwd(hz.uses_rt_fd, hz.rt_addr_fd);
            end
        end
        if (e_frz != 0) pend++;
        else begin
            if (pend == MW && !hz.mem_ready) m_err = 1;
            pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously; outputs must drop before any clock edge.
    task automatic do_reset();
        rst   = 1'b1;
        pend  = 0;
        m_a   = 0;
        m_b   = 0;
        m_err = 0;
        m_cnt = 0;
        e_frz = 0;
        e_haz = 0;
        #1;
        chk("rst freeze", hz.freeze, 0);
        chk("rst stall_fd", hz.stall_fd, 0);
        chk("rst bubble_dx", hz.bubble_dx, 0);
        chk("rst alu_a_mux_sel", hz.alu_a_mux_sel, 0);
        chk("rst alu_b_mux_sel", hz.alu_b_mux_sel, 0);
        chk("rst timeout_err", hz.timeout_err, 0);
        chk("rst stall_cycles", hz.stall_cycles, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int nfrz;
        int brk;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // ALU producer in DX, ID reads rs -> forward from XM next cycle
        set_in(3, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0);
        eval_cycle();
        chk("alu dx stall_fd", hz.stall_fd, 0);
        adv();
        chk("alu dx sel_a", hz.alu_a_mux_sel, 2);

        // Both stages write r3: DX wins
        set_in(0, 3, 0, 1, 3, 1, 0, 3, 1, 0, 0);
        eval_cycle();
        adv();
        chk("dx prio sel_b", hz.alu_b_mux_sel, 2);
        chk("dx prio sel_a unused", hz.alu_a_mux_sel, 0);
        // DX writes r4 instead -> XM producer forwarded from MW
        set_in(0, 3, 0, 1, 4, 1, 0, 3, 1, 0, 0);
        eval_cycle();
        adv();
        chk("xm fwd sel_b", hz.alu_b_mux_sel, 1);

        // Load-use on rt=r5
        set_in(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0);
        eval_cycle();
        chk("load-use stall_fd", hz.stall_fd, 1);
        chk("load-use bubble_dx", hz.bubble_dx, 1);
        adv();
        chk("load-use sel_b", hz.alu_b_mux_sel, 0);
        chk("load-use count", hz.stall_cycles, 1);
        // Load now in XM with data ready, DX holds the bubble
        set_in(0, 5, 0, 1, 0, 0, 0, 5, 1, 1, 1);
        eval_cycle();
        chk("after load-use stall_fd", hz.stall_fd, 0);
        adv();
        chk("after load-use sel_b", hz.alu_b_mux_sel, 1);
        // Load to r0 is never a hazard
        set_in(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        eval_cycle();
        chk("r0 load stall_fd", hz.stall_fd, 0);
        adv();

        // Three-cycle memory wait; selects held despite a forwardable ID operand
        do_reset();
        set_in(1, 0, 1, 0, 1, 1, 0, 7, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            eval_cycle();
            chk("wait3 freeze", hz.freeze, 1);
            adv();
            chk("wait3 sel_a held", hz.alu_a_mux_sel, 0);
        end
        hz.mem_ready = 1'b1;
        eval_cycle();
        chk("wait3 release freeze", hz.freeze, 0);
        adv();
        chk("wait3 sel_a after", hz.alu_a_mux_sel, 2);
        chk("wait3 stall_cycles", hz.stall_cycles, 3);
        chk("wait3 timeout_err", hz.timeout_err, 0);

        // Memory never ready -> 16 frozen cycles, then abort with sticky error
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        nfrz = 0;
        brk  = -1;
        for (int i = 0; i < MW + 4; i++) begin
            eval_cycle();
            if (hz.freeze) nfrz++;
            else begin
                brk = i;
                break;
            end
            adv();
        end
        chk("timeout frozen cycles", nfrz, 16);
        chk("timeout release cycle", brk, 16);
        adv();
        chk("timeout_err set", hz.timeout_err, 1);
        chk("timeout stall_cycles", hz.stall_cycles, 16);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval_cycle();
        adv();
        chk("timeout_err sticky", hz.timeout_err, 1);

        // Ready arriving on the final wait cycle wins over the timeout
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        for (int i = 0; i < MW; i++) begin
            eval_cycle();
            chk("late ready freeze", hz.freeze, 1);
            adv();
        end
        hz.mem_ready = 1'b1;
        eval_cycle();
        chk("late ready freeze drop", hz.freeze, 0);
        adv();
        chk("late ready timeout_err", hz.timeout_err, 0);

        // Reset in the middle of a memory wait
        do_reset();
        set_in(1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        eval_cycle();
        adv();
        chk("mid rst pre sel_a", hz.alu_a_mux_sel, 2);
        set_in(1, 0, 1, 0, 1, 1, 0, 7, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            eval_cycle();
            adv();
        end
        chk("mid rst pre freeze", hz.freeze, 1);
        chk("mid rst pre count", hz.stall_cycles, 5);
        do_reset();

        // Randomized traffic; inputs are held while the model expects a freeze
        for (int c = 0; c < 3000; c++) begin
            if (e_frz != 0) begin
                hz.mem_ready = ($urandom_range(0, 11) == 0);
            end else begin
                set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                       ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 1),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
            end
            if ($urandom_range(0, 799) == 0) do_reset();
            eval_cycle();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
